// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store unit:
// access sizes, fault causes and FSM states.
`timescale 1ns/1ps
package mem_access_unit_pkg;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  localparam logic [1:0] MAU_CAUSE_NONE = 2'd0;
  localparam logic [1:0] MAU_CAUSE_MIS  = 2'd1;
  localparam logic [1:0] MAU_CAUSE_BUS  = 2'd2;
  localparam logic [1:0] MAU_CAUSE_TMO  = 2'd3;

  typedef enum logic [1:0] {
    MAU_IDLE  = 2'd0,
    MAU_ISSUE = 2'd1,
    MAU_DONE  = 2'd2
  } mau_state_t;

  function automatic logic [7:0] size_mask(
    input logic [1:0] size
  );
    logic [7:0] m;
    m = 8'h01;
    unique case (size)
      MEM_B:   m = 8'h01;
      MEM_H:   m = 8'h03;
      MEM_W:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Combinational lane logic: alignment check,
// store lane shifting and load extraction.
`timescale 1ns/1ps
module mau_align
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      size,
  input  logic [2:0]      off,
  input  logic            uns,
  input  logic [XLEN-1:0] wdata,
  input  logic [63:0]     rdata,
  output logic            misaligned,
  output logic [7:0]      wstrb,
  output logic [63:0]     wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [63:0] tmp;

  // alignment, store lanes and load extension
  always_comb begin
    misaligned = 1'b0;
    rdata_o    = '0;
    unique case (size)
      MEM_B:   misaligned = 1'b0;
      MEM_H:   misaligned = off[0];
      MEM_W:   misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
    wstrb   = size_mask(size) << off;
    wdata_o = wdata[63:0] << {off, 3'b000};
    tmp     = rdata >> {off, 3'b000};
    unique case (size)
      MEM_B: rdata_o = uns
        ? {{(XLEN-8){1'b0}}, tmp[7:0]}
        : {{(XLEN-8){tmp[7]}}, tmp[7:0]};
      MEM_H: rdata_o = uns
        ? {{(XLEN-16){1'b0}}, tmp[15:0]}
        : {{(XLEN-16){tmp[15]}}, tmp[15:0]};
      MEM_W: rdata_o = uns
        ? {{(XLEN-32){1'b0}}, tmp[31:0]}
        : {{(XLEN-32){tmp[31]}}, tmp[31:0]};
      default: rdata_o = tmp[XLEN-1:0];
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one op per transaction,
// hold-until-ack bus, extended load result.
`timescale 1ns/1ps
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [63:0]     mem_wdata,
  output logic [7:0]      mem_wstrb,
  input  logic            mem_ack,
  input  logic            mem_err,
  input  logic [63:0]     mem_rdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_fault,
  output logic [1:0]      rsp_cause
);

  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

  mau_state_t      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            store_q, store_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            fault_q, fault_d;
  logic [1:0]      cause_q, cause_d;

  logic            idle;
  logic            issue;
  logic            done;
  logic [1:0]      al_size;
  logic [2:0]      al_off;
  logic            al_mis;
  logic [7:0]      al_strb;
  logic [63:0]     al_wdata;
  logic [XLEN-1:0] al_rdata;

  assign idle  = (state_q == MAU_IDLE);
  assign issue = (state_q == MAU_ISSUE);
  assign done  = (state_q == MAU_DONE);

  assign al_size = idle ? req_size : size_q;
  assign al_off  = idle ? req_addr[2:0]
                        : addr_q[2:0];

  mau_align #(.XLEN(XLEN)) u_align (
    .size       (al_size),
    .off        (al_off),
    .uns        (uns_q),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .misaligned (al_mis),
    .wstrb      (al_strb),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  // state and request/response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MAU_IDLE;
      cnt_q   <= '0;
      store_q <= 1'b0;
      size_q  <= MEM_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
      cause_q <= MAU_CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
    end
  end

  // next state: accept, bus wait, respond
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    fault_d = fault_q;
    cause_d = cause_q;
    unique case (state_q)
      MAU_IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          if (al_mis) begin
            state_d = MAU_DONE;
            data_d  = '0;
            fault_d = 1'b1;
            cause_d = MAU_CAUSE_MIS;
          end else begin
            state_d = MAU_ISSUE;
          end
        end
      end
      MAU_ISSUE: begin
        if (mem_err) begin
          state_d = MAU_DONE;
          data_d  = '0;
          fault_d = 1'b1;
          cause_d = MAU_CAUSE_BUS;
        end else if (mem_ack) begin
          state_d = MAU_DONE;
          data_d  = store_q ? '0 : al_rdata;
          fault_d = 1'b0;
          cause_d = MAU_CAUSE_NONE;
        end else if (cnt_q >= TMO_LIM - 8'd1) begin
          state_d = MAU_DONE;
          data_d  = '0;
          fault_d = 1'b1;
          cause_d = MAU_CAUSE_TMO;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      MAU_DONE: state_d = MAU_IDLE;
      default:  state_d = MAU_IDLE;
    endcase
  end

  // bus and response outputs, zero when inactive
  always_comb begin
    req_ready = idle;
    mem_req   = issue;
    mem_we    = issue & store_q;
    mem_addr  = issue ? {addr_q[XLEN-1:3], 3'b000}
                      : '0;
    mem_wdata = (issue & store_q) ? al_wdata : '0;
    mem_wstrb = (issue & store_q) ? al_strb : '0;
    rsp_valid = done;
    rsp_data  = done ? data_q : '0;
    rsp_fault = done & fault_q;
    rsp_cause = done ? cause_q : MAU_CAUSE_NONE;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Vector-table bench for mem_access_unit with
// a response scoreboard and reset corner cases.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ack;
  logic        mem_err;
  logic [63:0] mem_rdata;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_fault;
  logic [1:0]  rsp_cause;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(64), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ack      (mem_ack),
    .mem_err      (mem_err),
    .mem_rdata    (mem_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_fault    (rsp_fault),
    .rsp_cause    (rsp_cause)
  );

  // kind: 0 ack, 1 err, 2 no reply, 3 ack+err, 4 misaligned
  typedef struct {
    string       name;
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          kind;
    int          dly;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata;
    logic [63:0] e_data;
    logic        e_fault;
    logic [1:0]  e_cause;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        fault;
    logic [1:0]  cause;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic add(input vec_t v);
    vq.push_back(v);
  endtask

  task automatic run(input vec_t v);
    int   n;
    int   cyc;
    int   lat;
    bit   got;
    exp_t e;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({v.name, ".ready"}, 64'(req_ready), 64'd1);
    req_store    = v.st;
    req_size     = v.sz;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_valid    = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb.push_back('{v.e_data, v.e_fault, v.e_cause});
    if (v.kind == 4) lat = 1;
    else if (v.kind == 2) lat = 5;
    else lat = 2 + v.dly;
    if (v.kind == 4) begin
      chk({v.name, ".no_req"}, 64'(mem_req), 64'd0);
    end else begin
      chk({v.name, ".req"}, 64'(mem_req), 64'd1);
      chk({v.name, ".addr"}, mem_addr,
          {v.addr[63:3], 3'b000});
      chk({v.name, ".we"}, 64'(mem_we), 64'(v.st));
      if (v.st) begin
        chk({v.name, ".strb"}, 64'(mem_wstrb),
            64'(v.e_strb));
        chk({v.name, ".wdata"}, mem_wdata, v.e_wdata);
      end
    end
    cyc = 1;
    got = 1'b0;
    while (!got && cyc <= 20) begin
      if (rsp_valid) begin
        got = 1'b1;
        chk({v.name, ".lat"}, 64'(cyc), 64'(lat));
        chk({v.name, ".rsp_req"}, 64'(mem_req), 64'd0);
        if (sb.size() == 0) begin
          chk({v.name, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk({v.name, ".data"}, rsp_data, e.data);
          chk({v.name, ".fault"}, 64'(rsp_fault),
              64'(e.fault));
          chk({v.name, ".cause"}, 64'(rsp_cause),
              64'(e.cause));
        end
      end else begin
        if (v.kind != 4 && v.kind != 2 &&
            cyc == 1 + v.dly) begin
          mem_rdata = v.rdata;
          mem_ack   = (v.kind == 0 || v.kind == 3);
          mem_err   = (v.kind == 1 || v.kind == 3);
        end
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_err   = 1'b0;
        mem_rdata = '0;
        cyc++;
        if (mem_req)
          chk({v.name, ".hold"}, mem_addr,
              {v.addr[63:3], 3'b000});
      end
    end
    if (!got) begin
      chk({v.name, ".rsp_seen"}, 64'd0, 64'd1);
    end else begin
      @(posedge clk); #1;
      chk({v.name, ".ready_back"},
          64'(req_ready), 64'd1);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_store    = 1'b0;
    req_size     = '0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    mem_ack      = 1'b0;
    mem_err      = 1'b0;
    mem_rdata    = '0;

    add('{"LB", 0, 0, 0, 64'h1003, 0,
          64'h00000000_80000000, 0, 0, 0, 0,
          64'hFFFFFFFF_FFFFFF80, 0, 0});
    add('{"LWU", 0, 2, 1, 64'h2004, 0,
          64'h89ABCDEF_00000000, 0, 0, 0, 0,
          64'h00000000_89ABCDEF, 0, 0});
    add('{"LW", 0, 2, 0, 64'h2004, 0,
          64'h89ABCDEF_00000000, 0, 1, 0, 0,
          64'hFFFFFFFF_89ABCDEF, 0, 0});
    add('{"SH", 1, 1, 0, 64'h3006,
          64'hFFFFFFFF_FFFF1234, 0, 0, 0, 8'hC0,
          64'h12340000_00000000, 0, 0, 0});
    add('{"SW_mis", 1, 2, 0, 64'h4002, 64'h55,
          0, 4, 0, 0, 0, 0, 1, 1});
    add('{"LD_err", 0, 3, 0, 64'h5008, 0,
          64'h1111, 1, 1, 0, 0, 0, 1, 2});
    add('{"LB_tmo", 0, 0, 0, 64'h6000, 0,
          0, 2, 0, 0, 0, 0, 1, 3});
    add('{"LHU", 0, 1, 1, 64'h7002, 0,
          64'h00000000_F00D0000, 0, 2, 0, 0,
          64'h00000000_0000F00D, 0, 0});
    add('{"LH", 0, 1, 0, 64'h7002, 0,
          64'h00000000_F00D0000, 0, 0, 0, 0,
          64'hFFFFFFFF_FFFFF00D, 0, 0});
    add('{"SD_both", 1, 3, 0, 64'h8000,
          64'h01234567_89ABCDEF, 0, 3, 0, 8'hFF,
          64'h01234567_89ABCDEF, 0, 1, 2});
    add('{"LH_mis", 0, 1, 0, 64'h9001, 0,
          0, 4, 0, 0, 0, 0, 1, 1});
    add('{"LD_uns", 0, 3, 1, 64'hA000, 0,
          64'h80000000_00000001, 0, 0, 0, 0,
          64'h80000000_00000001, 0, 0});
    add('{"SB", 1, 0, 0, 64'hB007, 64'hAB,
          0, 0, 1, 8'h80,
          64'hAB000000_00000000, 0, 0, 0});
    add('{"LBU", 0, 0, 1, 64'hB007, 0,
          64'hFE000000_00000000, 0, 0, 0, 0,
          64'h00000000_000000FE, 0, 0});
    add('{"LD_mis", 0, 3, 0, 64'hC004, 0,
          0, 4, 0, 0, 0, 0, 1, 1});

    #12;
    chk("rst.ready", 64'(req_ready), 64'd1);
    chk("rst.req", 64'(mem_req), 64'd0);
    chk("rst.valid", 64'(rsp_valid), 64'd0);
    chk("rst.data", rsp_data, 64'd0);
    chk("rst.strb", 64'(mem_wstrb), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vq[i]) run(vq[i]);

    // stray completion while idle is ignored
    mem_ack = 1'b1;
    mem_err = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    mem_err = 1'b0;
    chk("stray.valid", 64'(rsp_valid), 64'd0);
    chk("stray.ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    chk("stray.valid2", 64'(rsp_valid), 64'd0);

    // reset pulse during ISSUE
    req_store    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 64'hD000;
    req_valid    = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstmid.req_before", 64'(mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.req_drop", 64'(mem_req), 64'd0);
    chk("rstmid.ready", 64'(req_ready), 64'd1);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rstmid.no_rsp", 64'(rsp_valid), 64'd0);
      chk("rstmid.idle_req", 64'(mem_req), 64'd0);
    end
    run(vq[0]);

    chk("sb.drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequential load/store unit downstream of the RV64I ALU. It accepts one memory operation per transaction, with the effective address already computed, and checks natural alignment. It drives a 64-bit aligned bus with a hold-until-ack handshake and returns a sign- or zero-extended load result, or a fault, to writeback.

## Interface
Parameters:
- `XLEN`, 64, datapath and address width.
- `TIMEOUT`, 255, maximum cycles to wait for `mem_ack`/`mem_err` before faulting; range 1..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous active-low.
- `req_valid` in 1: operation offered.
- `req_ready` out 1: unit can accept.
- `req_store` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = B, 1 = H, 2 = W, 3 = D.
- `req_unsigned` in 1: zero-extend load (LBU/LHU/LWU).
- `req_addr` in XLEN: effective address.
- `req_wdata` in XLEN: store data, right-justified.
- `mem_req` out 1: bus request.
- `mem_we` out 1: bus write.
- `mem_addr` out XLEN: doubleword-aligned address (`addr[2:0]` = 0).
- `mem_wdata` out 64: lane-shifted store data.
- `mem_wstrb` out 8: byte enables.
- `mem_ack` in 1: bus completion.
- `mem_err` in 1: bus error completion.
- `mem_rdata` in 64: read doubleword; valid with `mem_ack`.
- `rsp_valid` out 1: result pulse.
- `rsp_data` out XLEN: extended load data; 0 for stores and faults.
- `rsp_fault` out 1: operation faulted.
- `rsp_cause` out 2: 0 = none, 1 = misaligned, 2 = bus error, 3 = timeout.

## Operation
- States:
  - IDLE: `req_ready` = 1.
  - ISSUE: waits on the bus.
  - DONE: `rsp_valid` = 1 for one cycle, then returns to IDLE.
- IDLE, on `req_valid` high: the request fields are registered.
  - If misaligned, go to DONE with cause 1. The bus is never touched.
  - Otherwise go to ISSUE.
- Misaligned means:
  - H: `addr[0]` set.
  - W: `addr[1:0]` nonzero.
  - D: `addr[2:0]` nonzero.
- ISSUE:
  - `mem_req` = 1, with `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` held stable until completion.
  - `mem_ack` completes the access; go to DONE, cause 0.
  - `mem_err` completes with cause 2; `mem_err` wins if both are high.
  - A timeout counter increments each ISSUE cycle. When it reaches `TIMEOUT` with no completion, go to DONE with cause 3.
- Store lanes:
  - `off = addr[2:0]`.
  - `mem_wstrb = size_mask << off`, where `size_mask` = 01, 03, 0F, FF for B/H/W/D.
  - `mem_wdata = req_wdata << (8*off)`.
- Load extraction:
  - Shift: `tmp = mem_rdata >> (8*off)`.
  - Extend from the top bit of the selected width: sign-extend, or zero-extend when `req_unsigned` is set.
  - For size D, `req_unsigned` is ignored.
  - The result is registered on `mem_ack`.
- Stores with `mem_ack` return `rsp_data` = 0 and `rsp_fault` = 0.

## Timing
- Reset values (asynchronous): state IDLE, timeout counter 0, and all outputs 0, except `req_ready` = 1.
- Asserting `rst_n` mid-ISSUE drops `mem_req` immediately. No `rsp_valid` follows.
- Aligned op, accepted at edge 0:
  - `mem_req` is high from cycle 1.
  - Ack sampled at edge k; `rsp_valid` is high in cycle k+1.
  - `req_ready` returns in cycle k+2.
  - Minimum turnaround is 3 cycles when the ack arrives in the first ISSUE cycle.
- Misaligned op accepted at edge 0: `rsp_valid` is high in cycle 1.
- `mem_ack` or `mem_err` outside ISSUE is ignored.
- `req_valid` while `req_ready` = 0 is not consumed; upstream must hold it.
- The timeout counter clears on entering ISSUE. It saturates and never wraps.

## Structure
- Add to `rv64i.svh`:
  - size encodings (`MEM_B/H/W/D`);
  - fault cause codes (`MAU_CAUSE_*`);
  - the state typedef (`mau_state_t`: IDLE/ISSUE/DONE).
- Sub-module `mau_align`: purely combinational. It computes the misaligned flag, `mem_wstrb`, `mem_wdata` and the extended load data from size, offset, unsigned flag and data. It is instantiated once; the FSM and registers stay in `mem_access_unit`.

## Test plan
- LB: addr 0x1003, `mem_rdata` 0x00000000_80000000, ack in cycle 1 -> `mem_addr` 0x1000, `rsp_data` 0xFFFFFFFF_FFFFFF80, `rsp_valid` in cycle 2.
- LWU: addr 0x2004, `mem_rdata` 0x89ABCDEF_00000000 -> `rsp_data` 0x00000000_89ABCDEF; LW with the same inputs -> 0xFFFFFFFF_89ABCDEF.
- SH: addr 0x3006, `req_wdata` 0x1234 -> `mem_wstrb` 0xC0, `mem_wdata[63:48]` 0x1234, `mem_we` 1; `rsp_fault` 0.
- SW addr 0x4002 -> no `mem_req`, `rsp_valid` in cycle 1, cause 1; LD addr 0x5008 with `mem_err` -> cause 2.
- With `TIMEOUT`=4 and no ack -> `rsp_fault` with cause 3 after 4 ISSUE cycles; `mem_req` then 0.
- `rst_n` pulsed low during ISSUE -> `mem_req` drops asynchronously, no `rsp_valid`; the next request completes normally.
